midi_tx_fifo: RTL and testbench

//   Byte FIFO sitting directly upstream of the UART TX serialiser in the MIDI router.

---
 rtl/midi_tx_fifo_pkg.sv | 29 ++
 rtl/midi_tx_fifo_if.sv | 23 ++
 rtl/midi_fifo_mem.sv | 30 +++
 rtl/midi_tx_fifo.sv | 91 +++++++++
 tb/tb_midi_tx_fifo.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/midi_tx_fifo_pkg.sv
// Shared MIDI router constants: byte width, TX FIFO sizing and status-byte values.
package midi_tx_fifo_pkg;

  localparam int unsigned MIDI_BYTE_W        = 8;
  localparam int unsigned TX_FIFO_DEPTH_LOG2 = 4;

  localparam logic [7:0] MIDI_NOTE_OFF     = 8'h80;
  localparam logic [7:0] MIDI_NOTE_ON      = 8'h90;
  localparam logic [7:0] MIDI_POLY_AT      = 8'hA0;
  localparam logic [7:0] MIDI_CTRL_CHANGE  = 8'hB0;
  localparam logic [7:0] MIDI_PROG_CHANGE  = 8'hC0;
  localparam logic [7:0] MIDI_CHAN_AT      = 8'hD0;
  localparam logic [7:0] MIDI_PITCH_BEND   = 8'hE0;
  localparam logic [7:0] MIDI_SYSEX        = 8'hF0;
  localparam logic [7:0] MIDI_EOX          = 8'hF7;
  localparam logic [7:0] MIDI_CLOCK        = 8'hF8;
  localparam logic [7:0] MIDI_ACTIVE_SENSE = 8'hFE;
  localparam logic [7:0] MIDI_SYS_RESET    = 8'hFF;

  function automatic logic is_status(input logic [7:0] b);
    return b[7];
  endfunction

  // System real-time bytes may be interleaved anywhere in a message.
  function automatic logic is_realtime(input logic [7:0] b);
    return b >= MIDI_CLOCK;
  endfunction

endpackage

// File: rtl/midi_tx_fifo_if.sv
// Push/pop handshake between router, TX FIFO and UART serialiser.
interface midi_tx_fifo_if
  import midi_tx_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = MIDI_BYTE_W
);
  logic             wr;
  logic [WIDTH-1:0] data_i;
  logic             full_n;
  logic             rd;
  logic [WIDTH-1:0] data_o;
  logic             empty_n;

  modport master (
    output wr, data_i, rd,
    input  full_n, data_o, empty_n
  );

  modport slave (
    input  wr, data_i, rd,
    output full_n, data_o, empty_n
  );
endinterface

// File: rtl/midi_fifo_mem.sv
// DEPTH x WIDTH register file: reset clear, synchronous write, asynchronous read.
module midi_fifo_mem #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);
  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/midi_tx_fifo.sv
// FWFT byte FIFO feeding the MIDI UART TX serialiser, with sticky overflow and high-water mark.
module midi_tx_fifo
  import midi_tx_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = MIDI_BYTE_W,
  parameter int unsigned DEPTH_LOG2 = TX_FIFO_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              reset,
  midi_tx_fifo_if.slave     bus,
  output logic [DEPTH_LOG2:0] level,
  output logic [DEPTH_LOG2:0] hwm,
  output logic              overflow,
  input  logic              clr
);
  localparam int unsigned LvlW = DEPTH_LOG2 + 1;

  typedef logic [LvlW-1:0]       lvl_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  localparam lvl_t LvlFull = lvl_t'(1 << DEPTH_LOG2);

  ptr_t wr_ptr_q, rd_ptr_q;
  lvl_t level_q, level_d;
  lvl_t hwm_q, hwm_d;
  logic ovf_q, ovf_d;
  logic empty_n_q, full_n_q;
  logic push, pop, drop;

  always_comb begin
    pop  = bus.rd && (level_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push = bus.wr && ((level_q != LvlFull) || bus.rd);
    drop = bus.wr && !push;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + lvl_t'(1);
    end else if (pop && !push) begin
      level_d = level_q - lvl_t'(1);
    end

    hwm_d = hwm_q;
    if (clr || (level_d > hwm_q)) begin
      hwm_d = level_d;
    end

    // A drop in the same cycle as clr keeps the flag set.
    ovf_d = drop || (ovf_q && !clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      hwm_q     <= '0;
      ovf_q     <= 1'b0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_q + ptr_t'(push);
      rd_ptr_q  <= rd_ptr_q + ptr_t'(pop);
      level_q   <= level_d;
      hwm_q     <= hwm_d;
      ovf_q     <= ovf_d;
      empty_n_q <= (level_d != '0);
      full_n_q  <= (level_d != LvlFull);
    end
  end

  midi_fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.data_i),
    .raddr (rd_ptr_q),
    .rdata (bus.data_o)
  );

  assign bus.full_n  = full_n_q;
  assign bus.empty_n = empty_n_q;
  assign level       = level_q;
  assign hwm         = hwm_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_midi_tx_fifo.sv
// Queue-based reference model of the MIDI TX FIFO, directed scenarios plus randomized traffic.
module tb_midi_tx_fifo;
  import midi_tx_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0;
  logic [4:0] level;
  logic [4:0] hwm;
  logic       overflow;
  logic       chk_en = 1'b0;

  int total = 0;
  int bad = 0;

  byte unsigned mq[$];
  int           m_hwm;
  bit           m_ovf;

  midi_tx_fifo_if #(.WIDTH(8)) bus ();

  midi_tx_fifo dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .level    (level),
    .hwm      (hwm),
    .overflow (overflow),
    .clr      (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_hwm = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic void model_step(input bit wr, input byte unsigned d, input bit rd,
                                     input bit c);
    bit push, pop, drop;
    pop  = rd && (mq.size() > 0);
    push = wr && ((mq.size() < DEPTH) || rd);
    drop = wr && !push;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(d);
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (c) m_hwm = mq.size();
    else if (mq.size() > m_hwm) m_hwm = mq.size();
  endfunction

  task automatic step(input bit wr, input byte unsigned d, input bit rd, input bit c);
    bus.wr     = wr;
    bus.data_i = d;
    bus.rd     = rd;
    clr        = c;
    @(posedge clk);
    model_step(wr, d, rd, c);
    #2;
  endtask

  task automatic async_reset(input string tag);
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    clr    = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk({tag, "_level"}, int'(level), 0);
    chk({tag, "_hwm"}, int'(hwm), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_empty_n"}, int'(bus.empty_n), 0);
    chk({tag, "_full_n"}, int'(bus.full_n), 1);
    chk({tag, "_data_o"}, int'(bus.data_o), 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  // Every cycle out of reset: DUT outputs against the queue model.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("level", int'(level), mq.size());
      chk("empty_n", int'(bus.empty_n), int'(mq.size() != 0));
      chk("full_n", int'(bus.full_n), int'(mq.size() != DEPTH));
      chk("hwm", int'(hwm), m_hwm);
      chk("overflow", int'(overflow), int'(m_ovf));
      if (mq.size() > 0) chk("data_o", int'(bus.data_o), int'(mq[0]));
    end
  end

  initial begin
    bus.wr     = 1'b0;
    bus.rd     = 1'b0;
    bus.data_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;

    // Reads on an empty FIFO are ignored
    repeat (20) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_empty_n", int'(bus.empty_n), 0);
    chk("t1_level", int'(level), 0);
    chk("t1_data_o", int'(bus.data_o), 0);
    chk("t1_overflow", int'(overflow), 0);

    // Note-on message, FWFT latency of one cycle
    step(1'b1, MIDI_NOTE_ON, 1'b0, 1'b0);
    chk("t2_empty_n", int'(bus.empty_n), 1);
    chk("t2_data_o", int'(bus.data_o), 'h90);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'h64, 1'b0, 1'b0);
    chk("t2_level", int'(level), 3);
    chk("t2_hwm", int'(hwm), 3);
    chk("t2_data_o_hold", int'(bus.data_o), 'h90);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Overfill by one, then drain in order
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 15) chk("t3_full_n", int'(bus.full_n), 0);
    end
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_level", int'(level), 16);
    for (int i = 0; i < 16; i++) begin
      chk("t3_pop_data", int'(bus.data_o), i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t3_empty_n", int'(bus.empty_n), 0);

    // Full streaming across pointer wrap
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t4_clr_overflow", int'(overflow), 0);
    chk("t4_clr_hwm", int'(hwm), 0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk("t4_stream_data", int'(bus.data_o), i);
      step(1'b1, 8'(16 + i), 1'b1, 1'b0);
      chk("t4_level", int'(level), 16);
      chk("t4_overflow", int'(overflow), 0);
    end

    // Simultaneous rd+wr on empty, clr behaviour
    repeat (16) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, MIDI_CLOCK, 1'b1, 1'b0);
    chk("t5_level", int'(level), 1);
    chk("t5_data_o", int'(bus.data_o), 'hF8);
    for (int i = 0; i < 15; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("t5_drop_overflow", int'(overflow), 1);
    step(1'b1, 8'hBB, 1'b0, 1'b1);
    chk("t5_set_wins", int'(overflow), 1);
    chk("t5_set_wins_hwm", int'(hwm), 16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_clr_overflow", int'(overflow), 0);
    chk("t5_clr_hwm_full", int'(hwm), 16);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_clr_hwm", int'(hwm), 12);
    chk("t5_clr_level", int'(level), 12);

    // Asynchronous reset mid-stream
    repeat (12) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("t6_level_pre", int'(level), 5);
    async_reset("t6_rst");
    step(1'b1, MIDI_ACTIVE_SENSE, 1'b0, 1'b0);
    chk("t6_data_o", int'(bus.data_o), 'hFE);
    chk("t6_empty_n", int'(bus.empty_n), 1);

    // Randomized traffic with alternating fill/drain bias
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int pw, pr;
      case ((cyc / 64) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      if (cyc == 750) async_reset("rand_rst");
      step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
           $urandom_range(99) < 3);
    end

    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
